// File: rtl/ic_pkg.sv
// Shared definitions for the interconnect memory router.
//   ADDR_W / DATA_W / STRB_W : bus field widths
//   ic_req_t                 : request fields broadcast to every target
//   slot_w()                 : width of a slot index covering N targets plus the error slot
package ic_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    typedef struct packed {
        logic              wen;
        logic [STRB_W-1:0] strb;
        logic [DATA_W-1:0] wdata;
        logic [ADDR_W-1:0] addr;
    } ic_req_t;

    // Slot indices 0..n_tgt-1 are targets, n_tgt is the internal error slot.
    function automatic int slot_w(input int n_tgt);
        return (n_tgt < 1) ? 1 : $clog2(n_tgt + 1);
    endfunction

endpackage

// File: rtl/ic_id_fifo.sv
// Ordered FIFO of slot indices for outstanding transactions.
//   g_clk, g_reset : clock, async active-high reset (clears pointers, count, contents)
//   push / wdata   : enqueue an index (caller guarantees !full)
//   pop            : dequeue the head (caller guarantees !empty)
//   head           : oldest entry, routes the response path
//   tail           : newest entry, used to keep a single target outstanding
//   full / empty   : occupancy flags
module ic_id_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 2
) (
    input  logic             g_clk,
    input  logic             g_reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [WIDTH-1:0] tail,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr, tail_ptr;
    logic [CNT_W-1:0] count;

    // Explicit wrap so non-power-of-two-safe and DEPTH=1 both work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (int'(p) == DEPTH - 1) ? '0 : p + PTR_W'(1);
    endfunction

    assign tail_ptr = (wr_ptr == '0) ? PTR_W'(DEPTH - 1) : wr_ptr - PTR_W'(1);
    assign head     = mem[rd_ptr];
    assign tail     = mem[tail_ptr];
    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ic_mem_router.sv
// Single-initiator to N-target memory router with in-order responses.
//   g_clk, g_reset          : clock, async active-high reset
//   m_req/m_wen/m_strb/
//   m_wdata/m_addr, m_gnt   : initiator request channel
//   m_recv/m_error/m_rdata,
//   m_ack                   : initiator response channel
//   t_req/t_wen/t_strb/
//   t_wdata/t_addr, t_gnt   : per-target request channels (fields broadcast)
//   t_recv/t_error/t_rdata,
//   t_ack                   : per-target response channels
// Unmapped addresses go to an internal error slot that answers with
// m_error=1, m_rdata=0 the cycle after grant.
module ic_mem_router
    import ic_pkg::*;
#(
    parameter int                   N_TGT    = 2,
    parameter logic [32*N_TGT-1:0]  TGT_BASE = {32'h2000_0000, 32'h1000_0000},
    parameter logic [32*N_TGT-1:0]  TGT_MASK = {32'hFFFF_0000, 32'hFFFF_C000},
    parameter int                   DEPTH    = 2
) (
    input  logic                      g_clk,
    input  logic                      g_reset,
    input  logic                      m_req,
    input  logic                      m_wen,
    input  logic [STRB_W-1:0]         m_strb,
    input  logic [DATA_W-1:0]         m_wdata,
    input  logic [ADDR_W-1:0]         m_addr,
    output logic                      m_gnt,
    output logic                      m_recv,
    output logic                      m_error,
    output logic [DATA_W-1:0]         m_rdata,
    input  logic                      m_ack,
    output logic [N_TGT-1:0]          t_req,
    output logic [N_TGT-1:0]          t_wen,
    output logic [STRB_W*N_TGT-1:0]   t_strb,
    output logic [DATA_W*N_TGT-1:0]   t_wdata,
    output logic [ADDR_W*N_TGT-1:0]   t_addr,
    input  logic [N_TGT-1:0]          t_gnt,
    input  logic [N_TGT-1:0]          t_recv,
    input  logic [N_TGT-1:0]          t_error,
    input  logic [DATA_W*N_TGT-1:0]   t_rdata,
    output logic [N_TGT-1:0]          t_ack
);

    localparam int                SLOT_W   = slot_w(N_TGT);
    localparam logic [SLOT_W-1:0] ERR_SLOT = SLOT_W'(N_TGT);

    ic_req_t           req_in;
    logic [N_TGT-1:0]  hit;
    logic [SLOT_W-1:0] sel, head, tail;
    logic              full, empty, rdy, can_issue, push, pop;

    // Holds off issue for the first cycle after reset release.
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) rdy <= 1'b0;
        else         rdy <= 1'b1;
    end

    // Address decode, one comparator per target.
    for (genvar i = 0; i < N_TGT; i++) begin : g_dec
        assign hit[i] = (m_addr & TGT_MASK[i*ADDR_W +: ADDR_W]) ==
                        (TGT_BASE[i*ADDR_W +: ADDR_W] & TGT_MASK[i*ADDR_W +: ADDR_W]);
    end

    // Descending scan so the lowest hitting index wins.
    always_comb begin
        sel = ERR_SLOT;
        for (int i = N_TGT - 1; i >= 0; i--) begin
            if (hit[i]) sel = SLOT_W'(i);
        end
    end

    // Only one target may be outstanding at a time; that keeps responses
    // in order without reorder buffering.
    assign can_issue = rdy && !full && (empty || (tail == sel));

    assign req_in = '{wen: m_wen, strb: m_strb, wdata: m_wdata, addr: m_addr};
    assign t_wen   = {N_TGT{req_in.wen}};
    assign t_strb  = {N_TGT{req_in.strb}};
    assign t_wdata = {N_TGT{req_in.wdata}};
    assign t_addr  = {N_TGT{req_in.addr}};

    for (genvar i = 0; i < N_TGT; i++) begin : g_req
        assign t_req[i] = m_req && (sel == SLOT_W'(i)) && can_issue;
    end

    always_comb begin
        m_gnt = 1'b0;
        for (int i = 0; i < N_TGT; i++) begin
            if (sel == SLOT_W'(i)) m_gnt = t_gnt[i] && t_req[i];
        end
        if (sel == ERR_SLOT) m_gnt = can_issue && m_req;
    end

    // Response path follows the oldest outstanding slot.
    always_comb begin
        m_recv  = 1'b0;
        m_error = 1'b0;
        m_rdata = '0;
        t_ack   = '0;
        if (!empty) begin
            if (head == ERR_SLOT) begin
                m_recv  = 1'b1;
                m_error = 1'b1;
            end else begin
                for (int i = 0; i < N_TGT; i++) begin
                    if (head == SLOT_W'(i)) begin
                        m_recv   = t_recv[i];
                        m_error  = t_error[i];
                        m_rdata  = t_rdata[i*DATA_W +: DATA_W];
                        t_ack[i] = m_ack;
                    end
                end
            end
        end
    end

    assign push = m_req && m_gnt;
    assign pop  = m_recv && m_ack;

    ic_id_fifo #(
        .WIDTH (SLOT_W),
        .DEPTH (DEPTH)
    ) u_id_fifo (
        .g_clk   (g_clk),
        .g_reset (g_reset),
        .push    (push),
        .wdata   (sel),
        .pop     (pop),
        .head    (head),
        .tail    (tail),
        .full    (full),
        .empty   (empty)
    );

endmodule

// File: doc/ic_mem_router.md
IC_MEM_ROUTER -- requirements
Module: ic_mem_router

Interface
REQ-001 SHALL have parameter N_TGT, default 2: number of target ports, legal range 1..8.
REQ-002 SHALL have parameter TGT_BASE [32*N_TGT-1:0], default {32'h2000_0000, 32'h1000_0000}: base address per target; target i occupies slice i.
REQ-003 SHALL have parameter TGT_MASK [32*N_TGT-1:0], default {32'hFFFF_0000, 32'hFFFF_C000}: address match mask per target.
REQ-004 SHALL have parameter DEPTH, default 2: maximum outstanding transactions, power of two, range 1..8.
REQ-005 SHALL have port g_clk, input, 1 bit: the single clock.
REQ-006 SHALL have port g_reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have initiator request ports, all inputs: m_req (1), m_wen (1), m_strb (4), m_wdata (32), m_addr (32).
REQ-008 SHALL have initiator request output m_gnt (1).
REQ-009 SHALL have initiator response outputs m_recv (1), m_error (1), m_rdata (32), and response input m_ack (1).
REQ-010 SHALL have target request outputs t_req (N_TGT), t_wen (N_TGT), t_strb (4*N_TGT), t_wdata (32*N_TGT), t_addr (32*N_TGT).
REQ-011 SHALL have target request input t_gnt (N_TGT).
REQ-012 SHALL have target response inputs t_recv (N_TGT), t_error (N_TGT), t_rdata (32*N_TGT), and response output t_ack (N_TGT).

Function
REQ-013 Decode: target i SHALL be hit when (m_addr & MASK_i) == (BASE_i & MASK_i); the lowest index SHALL win on overlap; no hit SHALL select the internal error slot, index N_TGT.
REQ-014 A request SHALL be transferred on the cycle where req && gnt; a response SHALL be transferred on the cycle where recv && ack.
REQ-015 t_req[i] SHALL equal m_req && hit_i && can_issue; all other t_req bits SHALL be 0; wen/strb/wdata/addr SHALL broadcast to every target unchanged.
REQ-016 can_issue SHALL be true when count < DEPTH and either count == 0 or the newest queued index equals the decoded index. Different targets SHALL never be outstanding at once, which keeps responses in order.
REQ-017 m_gnt SHALL be t_gnt[sel] && t_req[sel] for a mapped target, and can_issue && m_req for the error slot.
REQ-018 Each accepted request SHALL push its slot index, log2(N_TGT+1) bits, into an ID FIFO of DEPTH entries; the 0..DEPTH counter SHALL track occupancy.
REQ-019 When the head slot is target h: m_recv SHALL be t_recv[h], m_error SHALL be t_error[h], m_rdata SHALL be t_rdata slice h, and t_ack[h] SHALL be m_ack; all other t_ack bits SHALL be 0.
REQ-020 When the head slot is the error slot: m_recv SHALL be 1, m_error SHALL be 1, m_rdata SHALL be 0; no target ack SHALL be driven.
REQ-021 An entry SHALL pop on m_recv && m_ack.
REQ-022 With FIFO empty, m_recv SHALL be 0 and all t_ack SHALL be 0; t_recv asserted with no outstanding entry SHALL be ignored.
REQ-023 Push and pop in the same cycle SHALL leave count unchanged; read and write pointers SHALL wrap modulo DEPTH.
REQ-024 When full (count == DEPTH), m_gnt SHALL be 0, and a pop in that cycle SHALL NOT enable a push in the same cycle.
REQ-025 Minimum latency: grant to m_recv SHALL be the target latency plus 0 cycles; error-slot response SHALL appear the cycle after grant.

Reset
REQ-026 g_reset SHALL asynchronously clear count, pointers and FIFO contents.
REQ-027 While reset is asserted, and in the first cycle after release, m_gnt, m_recv, t_req and t_ack SHALL be 0.
REQ-028 Reset mid-transaction SHALL discard outstanding entries; late target responses after reset SHALL be ignored as in REQ-022.

Structure
REQ-029 Bus field widths (ADDR_W=32, DATA_W=32, STRB_W=4) and the slot-index width function SHALL live in a shared package, ic_pkg.
REQ-030 The ID FIFO SHALL be a sub-module, ic_id_fifo, parametrised by WIDTH and DEPTH, with full/empty outputs.

Verification
REQ-031 Read 0x1000_0004: target 0 grants and returns rdata 0xDEADBEEF after 1 cycle -> m_recv=1, m_rdata=0xDEADBEEF, m_error=0, t_req[1] never high.
REQ-032 Two back-to-back reads to 0x2000_0000 and 0x2000_0004 with DEPTH=2 -> both granted consecutively; a third read is not granted until the first pops.
REQ-033 Read to 0x1000_0000 outstanding, then read to 0x2000_0000 -> m_gnt=0 until the first response pops, then t_req[1]=1.
REQ-034 Read to 0x3000_0000 (unmapped) -> m_gnt=1 immediately; next cycle m_recv=1, m_error=1, m_rdata=0; no t_req asserted.
REQ-035 m_ack held 0 for 3 cycles while t_recv[0]=1 -> m_recv stays 1 and t_ack[0]=0; pop occurs only on the m_ack cycle.
REQ-036 g_reset pulsed with 2 outstanding entries, then a stray t_recv[0]=1 -> m_recv=0, count=0, and the next request behaves as from empty.
